intc_svc_master: RTL and testbench

- Register-bus initiator that drives the interrupt controller's register block from the host side.
- On `cfg_start`, programs the controller's configuration registers from its cfg inputs.
- On an asserted controller interrupt output, it: reads status, reads vector, presents the pair to a downstream consumer over a valid/ready handshake, then issues the W1C clear write.
- Sits between the controller's register port and the CPU/service logic; same clock domain.

---
 rtl/intc_pkg.sv | 32 +++
 rtl/intc_svc_master_if.sv | 33 +++
 rtl/intc_irq_detect.sv | 32 +++
 rtl/intc_svc_master.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_intc_svc_master.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// ----------------------------------------------------------------------------
// intc_pkg
//   Shared definitions for the interrupt-controller service master:
//   register map of the controller's register block and the FSM state type.
//   Optional build macro INTC_SVC_CLR_VERIFY_EN adds the VERIFY state.
// ----------------------------------------------------------------------------
package intc_pkg;

   localparam logic [7:0] ADDR_ENABLE    = 8'h00;
   localparam logic [7:0] ADDR_MASK      = 8'h04;
   localparam logic [7:0] ADDR_CLEAR     = 8'h08;
   localparam logic [7:0] ADDR_MODE      = 8'h0C;
   localparam logic [7:0] ADDR_POLARITY  = 8'h10;
   localparam logic [7:0] ADDR_PWIDTH    = 8'h14;
   localparam logic [7:0] ADDR_STATUS    = 8'h18;
   localparam logic [7:0] ADDR_VECTOR    = 8'h1C;
   localparam logic [7:0] ADDR_PRIO_BASE = 8'h20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_RD_STAT,
      ST_RD_VEC,
      ST_PRESENT,
      ST_CLR,
      ST_HOLD
`ifdef INTC_SVC_CLR_VERIFY_EN
      ,ST_VERIFY
`endif
   } state_e;

endpackage

// File: rtl/intc_svc_master_if.sv
// ----------------------------------------------------------------------------
// intc_svc_master_if
//   Register bus (wr_en/rd_en/addr/wdata/rdata) towards the controller and
//   the service-record handshake (svc_valid/svc_ready/svc_vector/svc_status)
//   towards the consumer.
//   master : the service master (drives strobes and the record)
//   slave  : responder side (drives rdata and svc_ready)
// ----------------------------------------------------------------------------
interface intc_svc_master_if #(
   parameter int N = 8
);
   localparam int VW = $clog2(N);

   logic          wr_en;
   logic          rd_en;
   logic [7:0]    addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          svc_valid;
   logic          svc_ready;
   logic [VW-1:0] svc_vector;
   logic [N-1:0]  svc_status;

   modport master (
      output wr_en, rd_en, addr, wdata, svc_valid, svc_vector, svc_status,
      input  rdata, svc_ready
   );

   modport slave (
      input  wr_en, rd_en, addr, wdata, svc_valid, svc_vector, svc_status,
      output rdata, svc_ready
   );
endinterface

// File: rtl/intc_irq_detect.sv
// ----------------------------------------------------------------------------
// intc_irq_detect
//   Turns the controller's irq line into a single-cycle detect.
//   Ports: clk, rst_n (async, active-low), irq, mode (0 level / 1 pulse),
//          polarity (1 active-high), enable (detection allowed), detect.
//   The previous-sample register follows irq every cycle regardless of
//   enable, so an edge that happens while detection is disabled is lost.
// ----------------------------------------------------------------------------
module intc_irq_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   input  logic mode,
   input  logic polarity,
   input  logic enable,
   output logic detect
);
   logic prev_q, prev_d;
   logic active, prev_active;

   always_comb begin
      prev_d      = irq;
      active      = (irq == polarity);
      prev_active = (prev_q == polarity);
      detect      = enable & (mode ? (active & ~prev_active) : active);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= prev_d;
   end
endmodule

// File: rtl/intc_svc_master.sv
// ----------------------------------------------------------------------------
// intc_svc_master
//   Register-bus initiator for the interrupt controller.
//   - cfg_start: latches cfg_* into shadows and writes them to the controller
//     (pulse width, mode, polarity, N priorities, mask, enable last).
//   - On detected irq: read STATUS, read VECTOR, present the pair on the
//     svc handshake, then write the one-hot W1C clear. Zero status counts as
//     spurious (saturating spurious_cnt) and is not presented or cleared.
//   Ports: clk, rst_n (async active-low), cfg_* inputs, cfg_busy, irq,
//          spurious_cnt, bus (intc_svc_master_if.master),
//          clr_err (only with INTC_SVC_CLR_VERIFY_EN).
//   Build macro INTC_SVC_CLR_VERIFY_EN: after each clear, wait HOLDOFF cycles,
//   re-read STATUS and re-issue the clear up to 3 times; clr_err pulses when
//   the bit is still set after the last retry.
//   All bus and record outputs are registered from the next-state decode.
// ----------------------------------------------------------------------------
module intc_svc_master
   import intc_pkg::*;
#(
   parameter int N       = 8,
   parameter int P       = 3,
   parameter int W       = 8,
   parameter int HOLDOFF = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           cfg_start,
   input  logic [N-1:0]   cfg_enable,
   input  logic [N-1:0]   cfg_mask,
   input  logic           cfg_mode,
   input  logic           cfg_polarity,
   input  logic [W-1:0]   cfg_pulse_width,
   input  logic [N*P-1:0] cfg_priority,
   output logic           cfg_busy,
   input  logic           irq,
   output logic [7:0]     spurious_cnt,
`ifdef INTC_SVC_CLR_VERIFY_EN
   output logic           clr_err,
`endif
   intc_svc_master_if.master bus
);
   localparam int         VW        = $clog2(N);
   localparam logic [7:0] CFG_LAST  = 8'(N + 4);
   localparam logic [7:0] PRIO_END  = 8'(N + 3);
   localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);
`ifdef INTC_SVC_CLR_VERIFY_EN
   localparam logic [7:0] VRFY_RD   = 8'(HOLDOFF);
`endif

   state_e         state_q, state_d;
   logic [7:0]     cnt_q, cnt_d;
   logic           wr_en_q, wr_en_d, rd_en_q, rd_en_d;
   logic [7:0]     addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic           svc_valid_q, svc_valid_d, cfg_busy_q, cfg_busy_d;
   logic [N-1:0]   status_q, status_d;
   logic [VW-1:0]  vector_q, vector_d;
   logic [7:0]     spur_q, spur_d;
   logic [N-1:0]   sh_en_q, sh_en_d, sh_mask_q, sh_mask_d;
   logic           sh_mode_q, sh_mode_d, sh_pol_q, sh_pol_d;
   logic [W-1:0]   sh_pw_q, sh_pw_d;
   logic [N*P-1:0] sh_prio_q, sh_prio_d;
`ifdef INTC_SVC_CLR_VERIFY_EN
   logic [1:0]     retry_q, retry_d;
   logic           clr_err_q, clr_err_d;
`endif
   logic           detect;
   int             pidx;

   intc_irq_detect u_detect (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq      (irq),
      .mode     (sh_mode_q),
      .polarity (sh_pol_q),
      .enable   (state_q == ST_IDLE),
      .detect   (detect)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      status_d    = status_q;
      vector_d    = vector_q;
      spur_d      = spur_q;
      sh_en_d     = sh_en_q;
      sh_mask_d   = sh_mask_q;
      sh_mode_d   = sh_mode_q;
      sh_pol_d    = sh_pol_q;
      sh_pw_d     = sh_pw_q;
      sh_prio_d   = sh_prio_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      addr_d      = 8'h00;
      wdata_d     = 32'h0;
      svc_valid_d = 1'b0;
      cfg_busy_d  = 1'b0;
      pidx        = 0;
`ifdef INTC_SVC_CLR_VERIFY_EN
      retry_d     = retry_q;
      clr_err_d   = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            // Configuration has priority over a simultaneous detection.
            if (cfg_start) begin
               sh_en_d   = cfg_enable;
               sh_mask_d = cfg_mask;
               sh_mode_d = cfg_mode;
               sh_pol_d  = cfg_polarity;
               sh_pw_d   = cfg_pulse_width;
               sh_prio_d = cfg_priority;
               cnt_d     = 8'd0;
               state_d   = ST_CFG;
            end else if (detect) begin
               state_d = ST_RD_STAT;
            end
         end
         ST_CFG: begin
            if (cnt_q == CFG_LAST) begin
               cnt_d   = 8'd0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RD_STAT: begin
            status_d = bus.rdata[N-1:0];
            state_d  = ST_RD_VEC;
         end
         ST_RD_VEC: begin
            vector_d = bus.rdata[VW-1:0];
            if (status_q == '0) begin
               if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
               cnt_d   = 8'd0;
               state_d = ST_HOLD;
            end else begin
               state_d = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (bus.svc_ready) begin
               state_d = ST_CLR;
`ifdef INTC_SVC_CLR_VERIFY_EN
               retry_d = 2'd0;
`endif
            end
         end
         ST_CLR: begin
            cnt_d = 8'd0;
`ifdef INTC_SVC_CLR_VERIFY_EN
            state_d = ST_VERIFY;
`else
            state_d = ST_HOLD;
`endif
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) state_d = ST_IDLE;
            else                    cnt_d   = cnt_q + 8'd1;
         end
`ifdef INTC_SVC_CLR_VERIFY_EN
         // cnt 0..HOLDOFF-1 waits, cnt == HOLDOFF is the STATUS re-read.
         ST_VERIFY: begin
            if (cnt_q == VRFY_RD) begin
               cnt_d = 8'd0;
               if (!bus.rdata[vector_q]) begin
                  state_d = ST_HOLD;
               end else if (retry_q != 2'd3) begin
                  retry_d = retry_q + 2'd1;
                  state_d = ST_CLR;
               end else begin
                  clr_err_d = 1'b1;
                  state_d   = ST_HOLD;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Registered bus/record outputs decoded from the state being entered.
      case (state_d)
         ST_CFG: begin
            cfg_busy_d = 1'b1;
            wr_en_d    = 1'b1;
            if (cnt_d == 8'd0) begin
               addr_d  = ADDR_PWIDTH;
               wdata_d = 32'(sh_pw_d);
            end else if (cnt_d == 8'd1) begin
               addr_d  = ADDR_MODE;
               wdata_d = 32'(sh_mode_d);
            end else if (cnt_d == 8'd2) begin
               addr_d  = ADDR_POLARITY;
               wdata_d = 32'(sh_pol_d);
            end else if (cnt_d < PRIO_END) begin
               pidx    = int'(cnt_d) - 3;
               addr_d  = ADDR_PRIO_BASE + 8'(4 * pidx);
               wdata_d = 32'(sh_prio_d[pidx*P +: P]);
            end else if (cnt_d == PRIO_END) begin
               addr_d  = ADDR_MASK;
               wdata_d = 32'(sh_mask_d);
            end else begin
               addr_d  = ADDR_ENABLE;
               wdata_d = 32'(sh_en_d);
            end
         end
         ST_RD_STAT: begin
            rd_en_d = 1'b1;
            addr_d  = ADDR_STATUS;
         end
         ST_RD_VEC: begin
            rd_en_d = 1'b1;
            addr_d  = ADDR_VECTOR;
         end
         ST_PRESENT: svc_valid_d = 1'b1;
         ST_CLR: begin
            wr_en_d = 1'b1;
            addr_d  = ADDR_CLEAR;
            wdata_d = 32'd1 << vector_d;
         end
`ifdef INTC_SVC_CLR_VERIFY_EN
         ST_VERIFY: begin
            if (cnt_d == VRFY_RD) begin
               rd_en_d = 1'b1;
               addr_d  = ADDR_STATUS;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 8'd0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 32'h0;
         svc_valid_q <= 1'b0;
         cfg_busy_q  <= 1'b0;
         status_q    <= '0;
         vector_q    <= '0;
         spur_q      <= 8'd0;
         sh_en_q     <= '0;
         sh_mask_q   <= '0;
         sh_mode_q   <= 1'b0;
         sh_pol_q    <= 1'b0;
         sh_pw_q     <= '0;
         sh_prio_q   <= '0;
`ifdef INTC_SVC_CLR_VERIFY_EN
         retry_q     <= 2'd0;
         clr_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         svc_valid_q <= svc_valid_d;
         cfg_busy_q  <= cfg_busy_d;
         status_q    <= status_d;
         vector_q    <= vector_d;
         spur_q      <= spur_d;
         sh_en_q     <= sh_en_d;
         sh_mask_q   <= sh_mask_d;
         sh_mode_q   <= sh_mode_d;
         sh_pol_q    <= sh_pol_d;
         sh_pw_q     <= sh_pw_d;
         sh_prio_q   <= sh_prio_d;
`ifdef INTC_SVC_CLR_VERIFY_EN
         retry_q     <= retry_d;
         clr_err_q   <= clr_err_d;
`endif
      end
   end

   // Upper rdata bits are not part of any register this block reads.
   logic unused_rdata;
   assign unused_rdata = ^bus.rdata;

   assign bus.wr_en      = wr_en_q;
   assign bus.rd_en      = rd_en_q;
   assign bus.addr       = addr_q;
   assign bus.wdata      = wdata_q;
   assign bus.svc_valid  = svc_valid_q;
   assign bus.svc_vector = vector_q;
   assign bus.svc_status = status_q;
   assign cfg_busy       = cfg_busy_q;
   assign spurious_cnt   = spur_q;
`ifdef INTC_SVC_CLR_VERIFY_EN
   assign clr_err        = clr_err_q;
`endif
endmodule

// File: tb/tb_intc_svc_master.sv
// ----------------------------------------------------------------------------
// tb_intc_svc_master
//   Directed bench for intc_svc_master (default build; clr_err is connected
//   when INTC_SVC_CLR_VERIFY_EN is defined). A combinational responder returns
//   stat_val for STATUS reads and vec_val for VECTOR reads.
// ----------------------------------------------------------------------------
module tb_intc_svc_master;
   localparam int N = 8, P = 3, W = 8, HOLDOFF = 2;

   logic           clk = 1'b0;
   logic           rst_n, cfg_start, cfg_mode, cfg_polarity, irq, svc_ready;
   logic [N-1:0]   cfg_enable, cfg_mask;
   logic [W-1:0]   cfg_pulse_width;
   logic [N*P-1:0] cfg_priority;
   logic           cfg_busy;
   logic [7:0]     spurious_cnt;
   logic [31:0]    stat_val, vec_val;
`ifdef INTC_SVC_CLR_VERIFY_EN
   logic           clr_err;
`endif
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] wdata;
   } wr_t;
   wr_t cfg_tbl [N+5];

   intc_svc_master_if #(.N(N)) bus ();

   assign bus.rdata = !bus.rd_en            ? 32'h0 :
                      (bus.addr == 8'h18)   ? stat_val :
                      (bus.addr == 8'h1C)   ? vec_val  : 32'hDEAD_BEEF;
   assign bus.svc_ready = svc_ready;

   intc_svc_master #(.N(N), .P(P), .W(W), .HOLDOFF(HOLDOFF)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cfg_start       (cfg_start),
      .cfg_enable      (cfg_enable),
      .cfg_mask        (cfg_mask),
      .cfg_mode        (cfg_mode),
      .cfg_polarity    (cfg_polarity),
      .cfg_pulse_width (cfg_pulse_width),
      .cfg_priority    (cfg_priority),
      .cfg_busy        (cfg_busy),
      .irq             (irq),
      .spurious_cnt    (spurious_cnt),
`ifdef INTC_SVC_CLR_VERIFY_EN
      .clr_err         (clr_err),
`endif
      .bus             (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      bit sv_seen, wr_seen, rd_seen;

      // Expected configuration write sequence for enable FF, mask 00,
      // mode 0, polarity 1, pulse width 4, priority[i] = i.
      cfg_tbl[0] = '{8'h14, 32'd4};
      cfg_tbl[1] = '{8'h0C, 32'd0};
      cfg_tbl[2] = '{8'h10, 32'd1};
      for (int i = 0; i < N; i++) cfg_tbl[3+i] = '{8'(32'h20 + 4*i), 32'(i)};
      cfg_tbl[N+3] = '{8'h04, 32'h00};
      cfg_tbl[N+4] = '{8'h00, 32'hFF};

      rst_n = 1'b0; cfg_start = 1'b0; irq = 1'b1; svc_ready = 1'b0;
      stat_val = 32'h0; vec_val = 32'h0;
      cfg_enable = 8'hFF; cfg_mask = 8'h00; cfg_mode = 1'b0; cfg_polarity = 1'b1;
      cfg_pulse_width = 8'd4;
      for (int i = 0; i < N; i++) cfg_priority[i*P +: P] = 3'(i);

      // ---- reset values ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cfg_busy",   32'(cfg_busy), 0);
      chk("rst_wr_en",      32'(bus.wr_en), 0);
      chk("rst_rd_en",      32'(bus.rd_en), 0);
      chk("rst_addr",       32'(bus.addr), 0);
      chk("rst_wdata",      bus.wdata, 0);
      chk("rst_svc_valid",  32'(bus.svc_valid), 0);
      chk("rst_spurious",   32'(spurious_cnt), 0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // ---- configuration sequence ----
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      irq = 1'b0;
      for (int k = 0; k < N + 5; k++) begin
         chk($sformatf("cfg_busy[%0d]", k),  32'(cfg_busy), 1);
         chk($sformatf("cfg_wr_en[%0d]", k), 32'({bus.wr_en, bus.rd_en}), 32'b10);
         chk($sformatf("cfg_addr[%0d]", k),  32'(bus.addr), 32'(cfg_tbl[k].addr));
         chk($sformatf("cfg_wdata[%0d]", k), bus.wdata, cfg_tbl[k].wdata);
         tick();
      end
      chk("cfg_busy_end", 32'(cfg_busy), 0);
      chk("cfg_wr_end",   32'(bus.wr_en), 0);
      repeat (3) tick();

      // ---- level service, ready held high ----
      stat_val = 32'h08; vec_val = 32'd3; svc_ready = 1'b1;
      irq = 1'b1;
      tick();
      chk("lvl_rd_stat_en",   32'({bus.wr_en, bus.rd_en}), 32'b01);
      chk("lvl_rd_stat_addr", 32'(bus.addr), 32'h18);
      irq = 1'b0;
      tick();
      chk("lvl_rd_vec_en",    32'(bus.rd_en), 1);
      chk("lvl_rd_vec_addr",  32'(bus.addr), 32'h1C);
      tick();
      chk("lvl_valid",        32'(bus.svc_valid), 1);
      chk("lvl_vector",       32'(bus.svc_vector), 3);
      chk("lvl_status",       32'(bus.svc_status), 32'h08);
      chk("lvl_present_bus",  32'({bus.wr_en, bus.rd_en, bus.addr}), 0);
      tick();
      chk("lvl_clr_en",       32'({bus.wr_en, bus.rd_en}), 32'b10);
      chk("lvl_clr_addr",     32'(bus.addr), 32'h08);
      chk("lvl_clr_data",     bus.wdata, 32'h08);
      chk("lvl_valid_drop",   32'(bus.svc_valid), 0);
      tick();
      chk("lvl_idle_bus",     32'({bus.wr_en, bus.rd_en, bus.addr}), 0);
      chk("lvl_idle_wdata",   bus.wdata, 0);
      repeat (3) tick();

      // ---- backpressure: ready low for 5 cycles ----
      stat_val = 32'h20; vec_val = 32'd5; svc_ready = 1'b0;
      irq = 1'b1;
      tick();
      irq = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_valid[%0d]", i),  32'(bus.svc_valid), 1);
         chk($sformatf("bp_vector[%0d]", i), 32'(bus.svc_vector), 5);
         chk($sformatf("bp_status[%0d]", i), 32'(bus.svc_status), 32'h20);
         chk($sformatf("bp_nobus[%0d]", i),  32'({bus.wr_en, bus.rd_en}), 0);
         if (i == 4) svc_ready = 1'b1;
         tick();
      end
      chk("bp_clr_en",   32'(bus.wr_en), 1);
      chk("bp_clr_addr", 32'(bus.addr), 32'h08);
      chk("bp_clr_data", bus.wdata, 32'h20);
      tick();
      repeat (3) tick();

      // ---- spurious services and saturation ----
      stat_val = 32'h0; vec_val = 32'h0;
      irq = 1'b1;
      tick();
      tick();
      tick();
      chk("spur_first",      32'(spurious_cnt), 1);
      chk("spur_no_valid",   32'(bus.svc_valid), 0);
      chk("spur_no_wr",      32'(bus.wr_en), 0);
      sv_seen = 1'b0; wr_seen = 1'b0;
      repeat (1300) begin
         tick();
         if (bus.svc_valid) sv_seen = 1'b1;
         if (bus.wr_en)     wr_seen = 1'b1;
      end
      irq = 1'b0;
      repeat (6) tick();
      chk("spur_saturated",  32'(spurious_cnt), 255);
      chk("spur_valid_seen", 32'(sv_seen), 0);
      chk("spur_wr_seen",    32'(wr_seen), 0);

      // ---- pulse mode: cfg_start together with a rising irq ----
      cfg_mode = 1'b1;
      cfg_start = 1'b1;
      irq = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("pls_cfg_first_busy", 32'(cfg_busy), 1);
      chk("pls_cfg_first_en",   32'({bus.wr_en, bus.rd_en}), 32'b10);
      chk("pls_cfg_first_addr", 32'(bus.addr), 32'h14);
      rd_seen = 1'b0;
      repeat (20) begin
         tick();
         if (bus.rd_en) rd_seen = 1'b1;
      end
      chk("pls_held_no_service", 32'(rd_seen), 0);
      stat_val = 32'h01; vec_val = 32'd0;
      irq = 1'b0;
      tick();
      irq = 1'b1;
      tick();
      chk("pls_edge_rd_en",   32'(bus.rd_en), 1);
      chk("pls_edge_rd_addr", 32'(bus.addr), 32'h18);
      tick();
      tick();
      chk("pls_valid",   32'(bus.svc_valid), 1);
      chk("pls_vector",  32'(bus.svc_vector), 0);
      chk("pls_status",  32'(bus.svc_status), 32'h01);
      tick();
      chk("pls_clr_data", bus.wdata, 32'h01);
      rd_seen = 1'b0;
      repeat (10) begin
         tick();
         if (bus.rd_en) rd_seen = 1'b1;
      end
      chk("pls_no_retrigger", 32'(rd_seen), 0);

      // ---- reset in the middle of PRESENT ----
      stat_val = 32'h80; vec_val = 32'd7; svc_ready = 1'b0;
      irq = 1'b0;
      tick();
      irq = 1'b1;
      tick();
      tick();
      tick();
      chk("mid_valid_before", 32'(bus.svc_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_valid_rst",    32'(bus.svc_valid), 0);
      chk("mid_strobes_rst",  32'({bus.wr_en, bus.rd_en}), 0);
      chk("mid_spurious_rst", 32'(spurious_cnt), 0);
      chk("mid_vector_rst",   32'(bus.svc_vector), 0);
      @(negedge clk) rst_n = 1'b1;
      rd_seen = 1'b0;
      repeat (3) begin
         tick();
         if (bus.rd_en || bus.svc_valid) rd_seen = 1'b1;
      end
      chk("mid_idle_quiet", 32'(rd_seen), 0);
      cfg_mode = 1'b0;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      chk("mid_idle_cfg_busy", 32'(cfg_busy), 1);
      chk("mid_idle_cfg_addr", 32'(bus.addr), 32'h14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
